uart_alu_link: RTL and testbench



---
 rtl/uart_alu_link_pkg.sv | 24 ++
 rtl/uart_frame_tx.sv | 72 +++++++
 rtl/uart_alu_link.sv | 172 +++++++++++++++++
 tb/tb_uart_alu_link.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_link_pkg.sv
// Shared constants, state encodings and helpers for the UART <-> ALU command link.
package uart_alu_link_pkg;

  localparam logic [7:0] HDR_IN  = 8'hAA;
  localparam logic [7:0] HDR_RES = 8'h55;
  localparam logic [7:0] HDR_ERR = 8'h5A;

  localparam logic [7:0] ERR_CHK = 8'h01;
  localparam logic [7:0] ERR_TMO = 8'h02;
  localparam logic [7:0] ERR_FRM = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_OP, ST_RX_A, ST_RX_B, ST_RX_CHK, ST_EXEC, ST_TX
  } link_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_LOAD, TX_WAITBUSY, TX_WAITIDLE
  } tx_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Streams a left-aligned byte buffer out through the UART start/busy handshake.
module uart_frame_tx
  import uart_alu_link_pkg::*;
#(
  parameter int NB = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NB+2:0][7:0]   buf_i,
  input  logic [2:0]           len_i,
  input  logic                 tx_busy_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
  output logic                 last_o,
  output logic                 done_o
);

  tx_state_e            state_q;
  logic [NB+2:0][7:0]   buf_q;
  logic [2:0]           idx_q;
  logic [7:0]           tx_data_q;
  logic                 tx_start_q, last_q, done_q;

  // The next byte to send always sits in the top slot; the buffer shifts up per byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        TX_IDLE: if (start_i) begin
          buf_q   <= buf_i;
          idx_q   <= len_i - 3'd1;
          state_q <= TX_LOAD;
        end
        TX_LOAD: if (!tx_busy_i) begin
          tx_data_q  <= buf_q[NB+2];
          tx_start_q <= 1'b1;
          last_q     <= (idx_q == 3'd0);
          state_q    <= TX_WAITBUSY;
        end
        TX_WAITBUSY: if (tx_busy_i) state_q <= TX_WAITIDLE;
        TX_WAITIDLE: if (!tx_busy_i) begin
          if (idx_q == 3'd0) begin
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            idx_q   <= idx_q - 3'd1;
            buf_q   <= {buf_q[NB+1:0], 8'h00};
            state_q <= TX_LOAD;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign last_o     = last_q;
  assign done_o     = done_q;

endmodule

// File: rtl/uart_alu_link.sv
// Packet receiver, checksum/timeout checker and ALU sequencer; response bytes go out via uart_frame_tx.
module uart_alu_link
  import uart_alu_link_pkg::*;
#(
  parameter int NB          = 1,
  parameter int ALU_LAT     = 1,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [8*NB-1:0]   alu_a,
  output logic [8*NB-1:0]   alu_b,
  output logic [7:0]        alu_op,
  input  logic [8*NB-1:0]   alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic [7:0]        ok_count,
  output logic [7:0]        err_count
);

  localparam int              W        = 8 * NB;
  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      LAT_LAST = 4'(ALU_LAT - 1);
  localparam logic [1:0]      IDX_LAST = 2'(NB - 1);

  link_state_e    state_q;
  logic [TW-1:0]  tmo_q;
  logic [7:0]     chk_q, op_q, alu_op_q, ok_q, err_q;
  logic [W-1:0]   a_q, b_q, alu_a_q, alu_b_q;
  logic [1:0]     idx_q;
  logic [3:0]     lat_q;
  logic           res_q;

  logic               err_go, res_go, in_rx, tx_last, tx_done;
  logic [7:0]         err_code, res_chk;
  logic [NB+2:0][7:0] frame_buf;
  logic [2:0]         frame_len;

  always_comb begin
    err_go    = 1'b0;
    err_code  = ERR_CHK;
    res_go    = 1'b0;
    in_rx     = (state_q == ST_RX_OP) || (state_q == ST_RX_A) ||
                (state_q == ST_RX_B)  || (state_q == ST_RX_CHK);
    if (in_rx) begin
      if (rx_valid && rx_ferr) begin
        err_go   = 1'b1;
        err_code = ERR_FRM;
      end else if (!rx_valid && tmo_q == TMO_LAST) begin
        err_go   = 1'b1;
        err_code = ERR_TMO;
      end else if (rx_valid && state_q == ST_RX_CHK && rx_data != chk_q) begin
        err_go   = 1'b1;
        err_code = ERR_CHK;
      end
    end
    if (state_q == ST_EXEC && lat_q == LAT_LAST) res_go = 1'b1;

    res_chk = {4'b0, alu_flags};
    for (int i = 0; i < NB; i++) res_chk = res_chk ^ alu_result[8*i +: 8];

    // Frames are packed first-byte-at-top so the transmitter only ever shifts up.
    frame_buf = '0;
    if (res_go) begin
      frame_buf[NB+2] = HDR_RES;
      for (int i = 0; i < NB; i++) frame_buf[NB+1-i] = alu_result[8*(NB-1-i) +: 8];
      frame_buf[1]    = {4'b0, alu_flags};
      frame_buf[0]    = res_chk;
      frame_len       = 3'(NB + 3);
    end else begin
      frame_buf[NB+2] = HDR_ERR;
      frame_buf[NB+1] = err_code;
      frame_len       = 3'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      chk_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
      res_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      ok_q     <= '0;
      err_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (rx_valid && !rx_ferr && rx_data == HDR_IN) begin
          state_q <= ST_RX_OP;
          tmo_q   <= '0;
          chk_q   <= '0;
        end
        ST_RX_OP, ST_RX_A, ST_RX_B, ST_RX_CHK: begin
          if (err_go) begin
            res_q   <= 1'b0;
            state_q <= ST_TX;
          end else if (rx_valid) begin
            tmo_q <= '0;
            chk_q <= chk_q ^ rx_data;
            if (state_q == ST_RX_OP) begin
              op_q    <= rx_data;
              idx_q   <= IDX_LAST;
              state_q <= ST_RX_A;
            end else if (state_q == ST_RX_A) begin
              a_q <= W'({a_q, rx_data});
              if (idx_q == 2'd0) begin
                idx_q   <= IDX_LAST;
                state_q <= ST_RX_B;
              end else idx_q <= idx_q - 2'd1;
            end else if (state_q == ST_RX_B) begin
              b_q <= W'({b_q, rx_data});
              if (idx_q == 2'd0) state_q <= ST_RX_CHK;
              else idx_q <= idx_q - 2'd1;
            end else begin
              // Checksum already verified by err_go being low.
              alu_a_q  <= a_q;
              alu_b_q  <= b_q;
              alu_op_q <= op_q;
              lat_q    <= '0;
              state_q  <= ST_EXEC;
            end
          end else tmo_q <= tmo_q + 1'b1;
        end
        ST_EXEC: if (res_go) begin
          res_q   <= 1'b1;
          state_q <= ST_TX;
        end else lat_q <= lat_q + 4'd1;
        ST_TX: if (tx_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (tx_last) begin
        if (res_q) ok_q  <= sat_inc(ok_q);
        else       err_q <= sat_inc(err_q);
      end
    end
  end

  uart_frame_tx #(.NB(NB)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start_i    (err_go | res_go),
    .buf_i      (frame_buf),
    .len_i      (frame_len),
    .tx_busy_i  (tx_busy),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .last_o     (tx_last),
    .done_o     (tx_done)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign busy      = (state_q != ST_IDLE);
  assign ok_count  = ok_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_alu_link.sv
// Directed plus randomized bench for uart_alu_link with a UART-side model and a packet-level reference.
module tb_uart_alu_link;
  localparam int NB = 2, ALU_LAT = 1, TMO = 1000;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, rx_ferr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, busy;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [7:0]  alu_op, ok_count, err_count;
  logic [3:0]  alu_flags;

  uart_alu_link #(.NB(NB), .ALU_LAT(ALU_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;
  assign alu_flags  = 4'b0;

  // UART transmitter model: goes busy for 3 cycles after each start.
  int         cyc = 0, last_rx_cyc = 0, dbl = 0, bsy_cnt = 0;
  logic       prev_start = 1'b0, hold_busy = 1'b0;
  logic [7:0] txq[$];
  int         startq[$];
  assign tx_busy = (bsy_cnt != 0) || hold_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) last_rx_cyc <= cyc;
    if (tx_start) begin
      txq.push_back(tx_data);
      startq.push_back(cyc);
      bsy_cnt <= 3;
    end else if (bsy_cnt != 0) bsy_cnt <= bsy_cnt - 1;
    prev_start <= tx_start;
    if (prev_start && tx_start) dbl <= dbl + 1;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  pkt_q[$], exp_q[$];
  int          exp_lat, ref_cyc, exp_ok = 0, exp_err = 0;
  logic        pend_good;
  logic [15:0] pend_a, pend_b, exp_a = 0, exp_b = 0;
  logic [7:0]  pend_op, exp_op = 0;

  task automatic make_pkt(input logic [7:0] op, input logic [15:0] a, b, input logic [7:0] cx);
    logic [7:0]  c;
    logic [15:0] r;
    c = op ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ cx;
    pkt_q = '{8'hAA, op, a[15:8], a[7:0], b[15:8], b[7:0], c};
    pend_good = (cx == 8'h00);
    pend_a = a; pend_b = b; pend_op = op;
    if (pend_good) begin
      r = a + b;
      exp_q   = '{8'h55, r[15:8], r[7:0], 8'h00, r[15:8] ^ r[7:0]};
      exp_lat = ALU_LAT + 2;
    end else begin
      exp_q   = '{8'h5A, 8'h01};
      exp_lat = 2;
    end
  endtask

  task automatic commit_model();
    if (pend_good) begin
      if (exp_ok < 255) exp_ok++;
      exp_a = pend_a; exp_b = pend_b; exp_op = pend_op;
    end else if (exp_err < 255) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr, input int gap);
    rx_data = b; rx_valid = 1'b1; rx_ferr = ferr;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int gapmax);
    txq.delete(); startq.delete();
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(pkt_q[i], 1'b0, (i == pkt_q.size() - 1) ? 0 : $urandom_range(0, gapmax));
      if (i == pkt_q.size() - 1) ref_cyc = last_rx_cyc;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || tx_busy) && k < 3000) begin @(posedge clk); #1; k++; end
    chk("return_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input int budget, input logic do_lat);
    int k = 0;
    while (txq.size() < exp_q.size() && k < budget) begin @(posedge clk); #1; k++; end
    wait_idle();
    chk({tag, "_len"}, txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? {24'd0, txq[i]} : 32'hxxxxxxxx, {24'd0, exp_q[i]});
    if (do_lat)
      chk({tag, "_lat"}, (startq.size() > 0) ? startq[0] - ref_cyc : -1, exp_lat);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_alu_a"}, {16'd0, alu_a}, {16'd0, exp_a});
    chk({tag, "_alu_b"}, {16'd0, alu_b}, {16'd0, exp_b});
    chk({tag, "_alu_op"}, {24'd0, alu_op}, {24'd0, exp_op});
    chk({tag, "_ok"}, {24'd0, ok_count}, exp_ok);
    chk({tag, "_err"}, {24'd0, err_count}, exp_err);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    check_state(tag);
  endtask

  initial begin
    int n, k;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Bad checksum leaves ALU operands at reset values
    make_pkt(8'h20, 16'h1234, 16'h0001, 8'h0F);
    send_pkt(0); check_frame("badchk", 100, 1'b1); commit_model(); check_state("badchk");

    make_pkt(8'h20, 16'h1234, 16'h0001, 8'h00);
    send_pkt(0); check_frame("good", 100, 1'b1); commit_model(); check_state("good");

    // Inter-byte timeout
    txq.delete(); startq.delete();
    send_byte(8'hAA, 1'b0, 0); send_byte(8'h20, 1'b0, 2); send_byte(8'h12, 1'b0, 0);
    ref_cyc = last_rx_cyc;
    exp_q = '{8'h5A, 8'h02}; exp_lat = TMO + 2; pend_good = 1'b0;
    check_frame("timeout", TMO + 200, 1'b1); commit_model(); check_state("timeout");

    make_pkt(8'($urandom), 16'($urandom), 16'($urandom), 8'h00);
    send_pkt(3); check_frame("post_tmo", 100, 1'b1); commit_model(); check_state("post_tmo");

    // Framing error inside a packet
    txq.delete(); startq.delete();
    send_byte(8'hAA, 1'b0, 1); send_byte(8'h20, 1'b0, 0); send_byte(8'hAA, 1'b1, 0);
    ref_cyc = last_rx_cyc;
    exp_q = '{8'h5A, 8'h03}; exp_lat = 2; pend_good = 1'b0;
    check_frame("ferr", 100, 1'b1); commit_model(); check_state("ferr");

    // 0xAA as operand data, transmitter held busy, bytes during TX dropped
    hold_busy = 1'b1;
    make_pkt(8'h31, 16'hAAAA, 16'($urandom), 8'h00);
    send_pkt(2);
    repeat (100) begin @(posedge clk); #1; end
    send_byte(8'hAA, 1'b0, 1); send_byte(8'h20, 1'b0, 1); send_byte(8'h11, 1'b0, 1);
    repeat (400) begin @(posedge clk); #1; end
    chk("hold_no_start", txq.size(), 0);
    chk("hold_busy", {31'd0, busy}, 1);
    hold_busy = 1'b0;
    check_frame("hold", 300, 1'b0); commit_model(); check_state("hold");
    repeat (50) begin @(posedge clk); #1; end
    chk("no_spurious", txq.size(), 5);

    for (int p = 0; p < 16; p++) begin
      make_pkt(8'($urandom), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      send_pkt(4); check_frame($sformatf("rnd%0d", p), 200, 1'b1); commit_model();
      check_state($sformatf("rnd%0d", p));
    end

    // Reset after the second response byte starts
    make_pkt(8'h42, 16'($urandom), 16'($urandom), 8'h00);
    send_pkt(1);
    k = 0;
    while (txq.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
    chk("mid_reached", {31'd0, txq.size() >= 2}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ok = 0; exp_err = 0; exp_a = 0; exp_b = 0; exp_op = 0;
    check_reset_vals("midrst");
    rst = 1'b0;
    n = txq.size();
    repeat (30) begin @(posedge clk); #1; end
    chk("midrst_quiet", txq.size(), n);

    make_pkt(8'($urandom), 16'($urandom), 16'($urandom), 8'h00);
    send_pkt(2); check_frame("after_rst", 100, 1'b1); commit_model(); check_state("after_rst");

    chk("no_b2b_start", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
